// File: rtl/mips_int_ctrl.sv
// Interrupt sequencer between the INT/NMI pins and the fetch stage.
// Stalls fetch and drains the pipeline, then saves the resume PC and vectors to
// the handler. Handles the return on ERET. Only one handler runs at a time.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no request being serviced, fetch runs freely
// DRAIN   | fetch stalled, waiting for the pipeline to empty (bounded)
// TAKE    | one cycle: redirect to vector, capture EPC/CAUSE
// SERVICE | handler running, waiting for ERET
// RETURN  | one cycle: redirect back to EPC
module mips_int_ctrl #(
  parameter logic [31:0] INT_VECTOR = 32'h0000_0080,
  parameter logic [31:0] NMI_VECTOR = 32'h0000_0100,
  parameter int unsigned DRAIN_MAX  = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        INT,
  input  logic        NMI,
  input  logic        INT_FLAG,
  input  logic        PIPE_EMPTY,
  input  logic [31:0] RESUME_PC,
  input  logic        ERET,
  output logic        STALL,
  output logic        REDIRECT,
  output logic [31:0] PC_OUT,
  output logic [31:0] EPC,
  output logic        IN_ISR,
  output logic        CAUSE,
  output logic        DRAIN_ERR
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_TAKE    = 3'd2,
    ST_SERVICE = 3'd3,
    ST_RETURN  = 3'd4
  } state_t;

  localparam logic [7:0] DRAIN_LIM = 8'(DRAIN_MAX);

  state_t      state, state_nxt;
  logic [7:0]  drain_cnt, drain_cnt_nxt;
  logic        nmi_q;
  logic        nmi_pend, nmi_pend_nxt;
  // Source chosen when leaving DRAIN; frozen so the vector, CAUSE and the
  // nmi_pend clear all agree even if an NMI edge lands during TAKE.
  logic        take_nmi, take_nmi_nxt;
  logic        err_set;
  logic        int_req;
  logic        stall_nxt, redirect_nxt, in_isr_nxt;
  logic [31:0] pc_nxt;

  assign int_req = INT & INT_FLAG & ~IN_ISR;

  // State register and all registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      drain_cnt <= '0;
      nmi_q     <= 1'b0;
      nmi_pend  <= 1'b0;
      take_nmi  <= 1'b0;
      STALL     <= 1'b0;
      REDIRECT  <= 1'b0;
      PC_OUT    <= '0;
      EPC       <= '0;
      IN_ISR    <= 1'b0;
      CAUSE     <= 1'b0;
      DRAIN_ERR <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
      nmi_q     <= NMI;
      nmi_pend  <= nmi_pend_nxt;
      take_nmi  <= take_nmi_nxt;
      STALL     <= stall_nxt;
      REDIRECT  <= redirect_nxt;
      PC_OUT    <= pc_nxt;
      IN_ISR    <= in_isr_nxt;
      if (state == ST_TAKE) begin
        EPC   <= RESUME_PC;
        CAUSE <= take_nmi;
      end
      if (err_set) DRAIN_ERR <= 1'b1;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they register.
  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    take_nmi_nxt  = take_nmi;
    err_set       = 1'b0;
    case (state)
      ST_IDLE: begin
        drain_cnt_nxt = '0;
        if (nmi_pend || int_req) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        drain_cnt_nxt = drain_cnt + 8'd1;
        if (!(nmi_pend || int_req)) begin
          state_nxt = ST_IDLE;
        end else if (PIPE_EMPTY || (drain_cnt == DRAIN_LIM)) begin
          state_nxt    = ST_TAKE;
          take_nmi_nxt = nmi_pend;
          err_set      = ~PIPE_EMPTY;
        end
      end
      ST_TAKE:    state_nxt = ST_SERVICE;
      ST_SERVICE: if (ERET) state_nxt = ST_RETURN;
      ST_RETURN:  state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase

    // A fresh edge wins over the clear so it is never lost.
    nmi_pend_nxt = nmi_pend;
    if (NMI && !nmi_q)                     nmi_pend_nxt = 1'b1;
    else if (state == ST_TAKE && take_nmi) nmi_pend_nxt = 1'b0;

    stall_nxt    = (state_nxt == ST_DRAIN) || (state_nxt == ST_TAKE);
    redirect_nxt = (state_nxt == ST_TAKE) || (state_nxt == ST_RETURN);
    in_isr_nxt   = (state_nxt == ST_SERVICE) || (state_nxt == ST_RETURN);
    pc_nxt       = '0;
    if (state_nxt == ST_TAKE)        pc_nxt = take_nmi_nxt ? NMI_VECTOR : INT_VECTOR;
    else if (state_nxt == ST_RETURN) pc_nxt = EPC;
  end

endmodule

// File: doc/mips_int_ctrl.md
# mips_int_ctrl

Interrupt sequencer for the pipelined MIPS CPU. It sits between the external `INT`/`NMI` pins and the fetch stage. It arbitrates between the two sources, with NMI taking priority over INT and INT masked by `INT_FLAG`. For each accepted interrupt it stalls fetch, waits for the pipeline to drain, saves the resume PC into EPC and redirects fetch to the interrupt vector. On `ERET` it redirects fetch back to EPC. Only one interrupt is serviced at a time; there is no nesting.

## Interface
- `INT_VECTOR`, 32'h0000_0080, fetch target for a maskable interrupt
- `NMI_VECTOR`, 32'h0000_0100, fetch target for a non-maskable interrupt
- `DRAIN_MAX`, 8, maximum number of cycles spent waiting for `PIPE_EMPTY` (range 1..255)

Ports:
- `CLK` in 1: system clock; all logic is rising-edge
- `RST_N` in 1: asynchronous, active-low reset
- `INT` in 1: maskable interrupt request, level-sensitive
- `NMI` in 1: non-maskable request, rising-edge-sensitive
- `INT_FLAG` in 1: interrupt enable; 1 permits INT to be accepted
- `PIPE_EMPTY` in 1: no valid instruction remains in ID/EX/MEM/WB
- `RESUME_PC` in 32: PC of the next instruction to fetch, valid while `STALL`=1
- `ERET` in 1: one-cycle pulse when an ERET instruction retires
- `STALL` out 1: freezes the PC and IF/ID
- `REDIRECT` out 1: one-cycle pulse; fetch loads `PC_OUT`
- `PC_OUT` out 32: redirect target
- `EPC` out 32: saved resume PC
- `IN_ISR` out 1: a handler is active
- `CAUSE` out 1: source of the current/last interrupt (1 = NMI, 0 = INT)
- `DRAIN_ERR` out 1: sticky flag, set when the drain times out; cleared only by reset

## Operation
- NMI edge detector:
  - register `NMI`; `nmi_pend` sets when `NMI`=1 and the registered `NMI`=0
  - `nmi_pend` clears only in TAKE when the NMI is taken
  - an edge arriving while `nmi_pend`=1 is merged into the existing pending request
- INT request: `int_req` = `INT & INT_FLAG & ~IN_ISR`. It is not latched; dropping `INT` withdraws the request.
- States: IDLE, DRAIN, TAKE, SERVICE, RETURN.
- IDLE:
  - if `nmi_pend` or `int_req` is set, go to DRAIN
  - `STALL`=1 from the first DRAIN cycle
  - clear the drain counter
- DRAIN:
  - `STALL`=1; the counter increments each cycle
  - go to TAKE when `PIPE_EMPTY`=1, or when counter == `DRAIN_MAX` (timeout also sets `DRAIN_ERR`)
  - if neither `nmi_pend` nor `int_req` is still set, abort to IDLE with `STALL`=0 next cycle
- TAKE, one cycle:
  - `REDIRECT`=1, `STALL`=1
  - `PC_OUT` = `NMI_VECTOR` if `nmi_pend`, else `INT_VECTOR`
  - `EPC` <= `RESUME_PC`; `CAUSE` <= `nmi_pend`
  - go to SERVICE
- SERVICE:
  - `IN_ISR`=1, `STALL`=0
  - on `ERET`=1 go to RETURN
  - new NMI edges latch into `nmi_pend` but are not taken here
- RETURN, one cycle:
  - `REDIRECT`=1, `PC_OUT`=`EPC`, `IN_ISR`=1
  - go to IDLE; a pending NMI is then taken via DRAIN
- `ERET` outside SERVICE is ignored.
- `PC_OUT` is 0 whenever `REDIRECT`=0.
- When `nmi_pend` and `int_req` are both set in the same cycle, NMI wins. INT stays un-latched and is re-evaluated after return.

## Timing
- Reset (async assert, sync release): state = IDLE; `STALL`, `REDIRECT`, `IN_ISR`, `CAUSE`, `DRAIN_ERR` and `nmi_pend` = 0; `PC_OUT` = 0; `EPC` = 0.
- Reset asserted mid-operation returns to IDLE immediately; a half-taken interrupt is lost.
- Latency with `PIPE_EMPTY` already 1:
  - request sampled at edge N
  - DRAIN during cycle N+1
  - TAKE/`REDIRECT` during cycle N+2
  - `IN_ISR`=1 from cycle N+3
- NMI adds one cycle of edge-detect latency on top of this.
- Worst-case drain: `DRAIN_MAX`+1 DRAIN cycles, then TAKE.
- `RESUME_PC` is sampled at the TAKE edge only.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- INT=1, INT_FLAG=1, PIPE_EMPTY=1 -> `REDIRECT` pulse 2 cycles after sampling, `PC_OUT`=32'h80, `EPC`=`RESUME_PC` (e.g. 32'h0000_0040), `CAUSE`=0; ERET -> `REDIRECT` with `PC_OUT`=32'h40, `IN_ISR` falls.
- INT=1, INT_FLAG=0 -> `STALL` never asserts; then NMI 0->1 -> vector 32'h100, `CAUSE`=1, irrespective of `INT_FLAG`.
- INT and NMI edge in the same cycle -> NMI taken; after ERET, INT (still high) is taken with `CAUSE`=0.
- NMI edge during SERVICE -> no redirect until ERET; RETURN, then DRAIN, then TAKE to 32'h100 with `EPC` = the return PC.
- PIPE_EMPTY held 0 -> TAKE after exactly 9 DRAIN cycles (`DRAIN_MAX`=8), `DRAIN_ERR`=1 and staying 1; INT dropped after 2 DRAIN cycles in a repeat run -> abort, `STALL`=0, no `REDIRECT`.
- `RST_N` pulled low during DRAIN -> all outputs 0 immediately; after release with no request, controller stays in IDLE.
